// File: rtl/video_write_ctrl.sv
// video_write_ctrl: shares the video block write port between CPU single writes and a bounded fill engine
// VIDEO_FILL_INC_EN adds fill_step so the fill value advances by fill_step after every fill write
module video_write_ctrl #(
    parameter int PAL_SIZE  = 16,
    parameter int TDEF_SIZE = 256,
    parameter int MAP_SIZE  = 1200
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        cpu_req,
    input  logic [1:0]  cpu_param,
    input  logic [10:0] cpu_index,
    input  logic [15:0] cpu_val,
    output logic        cpu_ack,
    output logic        cpu_err,
    input  logic        fill_start,
    input  logic [1:0]  fill_param,
    input  logic [10:0] fill_base,
    input  logic [10:0] fill_count,
    input  logic [15:0] fill_val,
`ifdef VIDEO_FILL_INC_EN
    input  logic [15:0] fill_step,
`endif
    output logic        fill_busy,
    output logic        fill_done,
    output logic        wen,
    output logic [1:0]  w_param,
    output logic [10:0] w_index,
    output logic [15:0] w_val
);
    typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;
    state_t      r_state;
    logic [1:0]  r_param;
    logic [10:0] r_cur;
    logic [11:0] r_end;
    logic [15:0] r_val;
    logic        w_cpu_acc, w_cpu_ok, w_fill_wr;
    logic [11:0] w_sum, w_lim, w_end, w_cur_nxt;
    function automatic logic [11:0] lim(input logic [1:0] p);
        return p == 2'd0 ? 12'(PAL_SIZE) : p == 2'd1 ? 12'(TDEF_SIZE) : 12'(MAP_SIZE);
    endfunction
    always_comb begin
        w_cpu_acc = cpu_req && !cpu_ack;
        w_cpu_ok  = {1'b0, cpu_index} < lim(cpu_param);
        w_lim     = lim(fill_param);
        w_sum     = {1'b0, fill_base} + {1'b0, fill_count};
        w_end     = w_sum < w_lim ? w_sum : w_lim;
        w_cur_nxt = {1'b0, r_cur} + 12'd1;
        w_fill_wr = r_state == FILL && !w_cpu_acc;
    end
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state   <= IDLE;
            r_param   <= '0;
            r_cur     <= '0;
            r_end     <= '0;
            r_val     <= '0;
            cpu_ack   <= 1'b0;
            cpu_err   <= 1'b0;
            fill_busy <= 1'b0;
            fill_done <= 1'b0;
            wen       <= 1'b0;
            w_param   <= '0;
            w_index   <= '0;
            w_val     <= '0;
        end else begin
            wen       <= 1'b0;
            fill_done <= 1'b0;
            cpu_ack   <= w_cpu_acc;
            cpu_err   <= w_cpu_acc && !w_cpu_ok;
            // an accepted CPU request owns the port even when rejected, so the fill stalls either way
            if (w_cpu_acc && w_cpu_ok) begin
                wen     <= 1'b1;
                w_param <= cpu_param;
                w_index <= cpu_index;
                w_val   <= cpu_val;
            end else if (w_fill_wr) begin
                wen     <= 1'b1;
                w_param <= r_param;
                w_index <= r_cur;
                w_val   <= r_val;
            end
            case (r_state)
                IDLE: if (fill_start) begin
                    r_param   <= fill_param;
                    r_cur     <= fill_base;
                    r_end     <= w_end;
                    r_val     <= fill_val;
                    fill_busy <= 1'b1;
                    r_state   <= {1'b0, fill_base} >= w_end ? DONE : FILL;
                end
                FILL: if (w_fill_wr) begin
                    r_cur <= r_cur + 11'd1;
`ifdef VIDEO_FILL_INC_EN
                    r_val <= r_val + fill_step;
`endif
                    if (w_cur_nxt >= r_end) r_state <= DONE;
                end
                DONE: begin
                    fill_done <= 1'b1;
                    fill_busy <= 1'b0;
                    r_state   <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_video_write_ctrl.sv
// tb_video_write_ctrl: directed checks of CPU writes, fills, clipping, contention and reset for video_write_ctrl
// Build with VIDEO_FILL_INC_EN defined to exercise the incrementing fill value
module tb_video_write_ctrl;
    logic        clk = 1'b0, resetn = 1'b0;
    logic        cpu_req = 1'b0;
    logic [1:0]  cpu_param = '0;
    logic [10:0] cpu_index = '0;
    logic [15:0] cpu_val = '0;
    logic        fill_start = 1'b0;
    logic [1:0]  fill_param = '0;
    logic [10:0] fill_base = '0, fill_count = '0;
    logic [15:0] fill_val = '0;
`ifdef VIDEO_FILL_INC_EN
    logic [15:0] fill_step = '0;
`endif
    logic        cpu_ack, cpu_err, fill_busy, fill_done, wen;
    logic [1:0]  w_param;
    logic [10:0] w_index;
    logic [15:0] w_val;
    int checks = 0, failures = 0;

    always #5 clk = ~clk;

    video_write_ctrl dut (
        .clk(clk), .resetn(resetn),
        .cpu_req(cpu_req), .cpu_param(cpu_param), .cpu_index(cpu_index), .cpu_val(cpu_val),
        .cpu_ack(cpu_ack), .cpu_err(cpu_err),
        .fill_start(fill_start), .fill_param(fill_param), .fill_base(fill_base),
        .fill_count(fill_count), .fill_val(fill_val),
`ifdef VIDEO_FILL_INC_EN
        .fill_step(fill_step),
`endif
        .fill_busy(fill_busy), .fill_done(fill_done),
        .wen(wen), .w_param(w_param), .w_index(w_index), .w_val(w_val)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_fill(input logic [1:0] p, input logic [10:0] b, input logic [10:0] c, input logic [15:0] v);
        fill_param = p; fill_base = b; fill_count = c; fill_val = v; fill_start = 1'b1;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        tick(); tick();
        checks++;
        if ({wen, cpu_ack, cpu_err, fill_busy, fill_done} !== 5'b0) begin
            failures++;
            $display("FAIL reset_ctrl got=%b want=00000", {wen, cpu_ack, cpu_err, fill_busy, fill_done});
        end
        checks++;
        if ({w_param, w_index, w_val} !== 29'd0) begin
            failures++;
            $display("FAIL reset_data got=%h want=0", {w_param, w_index, w_val});
        end
        resetn = 1'b1;
        tick();
    endtask

    task automatic test_cpu_in_range();
        cpu_req = 1'b1; cpu_param = 2'd0; cpu_index = 11'd5; cpu_val = 16'h0F80;
        tick();
        checks++;
        if ({wen, w_param, w_index, w_val, cpu_ack, cpu_err} !== {1'b1, 2'd0, 11'd5, 16'h0F80, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL cpu_write got wen=%b p=%0d i=%0d v=%h ack=%b err=%b want 1/0/5/0f80/1/0",
                     wen, w_param, w_index, w_val, cpu_ack, cpu_err);
        end
        tick();
        checks++;
        if ({wen, cpu_ack} !== 2'b00) begin
            failures++;
            $display("FAIL cpu_hold got wen=%b ack=%b want 0 0", wen, cpu_ack);
        end
        cpu_req = 1'b0;
        tick();
    endtask

    task automatic test_cpu_out_of_range();
        cpu_req = 1'b1; cpu_param = 2'd0; cpu_index = 11'd16; cpu_val = 16'h1234;
        tick();
        checks++;
        if ({wen, cpu_ack, cpu_err, w_index, w_val} !== {3'b011, 11'd5, 16'h0F80}) begin
            failures++;
            $display("FAIL cpu_oor_pal got wen=%b ack=%b err=%b i=%0d v=%h want 0/1/1/5/0f80",
                     wen, cpu_ack, cpu_err, w_index, w_val);
        end
        cpu_req = 1'b0;
        tick();
        checks++;
        if ({cpu_ack, cpu_err} !== 2'b00) begin
            failures++;
            $display("FAIL cpu_err_pulse got ack=%b err=%b want 0 0", cpu_ack, cpu_err);
        end
        cpu_req = 1'b1; cpu_param = 2'd3; cpu_index = 11'd1200;
        tick();
        checks++;
        if ({wen, cpu_ack, cpu_err} !== 3'b011) begin
            failures++;
            $display("FAIL cpu_oor_map got wen=%b ack=%b err=%b want 0 1 1", wen, cpu_ack, cpu_err);
        end
        cpu_req = 1'b0;
        tick();
        cpu_req = 1'b1; cpu_param = 2'd3; cpu_index = 11'd1199; cpu_val = 16'h00AA;
        tick();
        checks++;
        if ({wen, cpu_err, w_index, w_val} !== {2'b10, 11'd1199, 16'h00AA}) begin
            failures++;
            $display("FAIL cpu_map_last got wen=%b err=%b i=%0d v=%h want 1/0/1199/00aa", wen, cpu_err, w_index, w_val);
        end
        cpu_req = 1'b0;
        tick();
    endtask

    task automatic test_full_clear();
        start_fill(2'd3, 11'd0, 11'd1200, 16'h0000);
        tick();
        fill_start = 1'b0;
        checks++;
        if ({fill_busy, wen} !== 2'b10) begin
            failures++;
            $display("FAIL clear_start got busy=%b wen=%b want 1 0", fill_busy, wen);
        end
        for (int i = 0; i < 1200; i++) begin
            tick();
            checks++;
            if ({wen, w_param, w_index, w_val, fill_done} !== {1'b1, 2'd3, 11'(i), 16'h0, 1'b0}) begin
                failures++;
                $display("FAIL clear_write[%0d] got wen=%b p=%0d i=%0d v=%h done=%b", i, wen, w_param, w_index, w_val, fill_done);
            end
        end
        tick();
        checks++;
        if ({wen, fill_done, fill_busy} !== 3'b010) begin
            failures++;
            $display("FAIL clear_done got wen=%b done=%b busy=%b want 0 1 0", wen, fill_done, fill_busy);
        end
        tick();
        checks++;
        if (fill_done !== 1'b0) begin
            failures++;
            $display("FAIL clear_done_pulse got %b want 0", fill_done);
        end
    endtask

    task automatic test_clip_and_zero();
        start_fill(2'd1, 11'd250, 11'd20, 16'hABCD);
        tick();
        fill_start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++;
            if ({wen, w_param, w_index, w_val} !== {1'b1, 2'd1, 11'(250 + i), 16'hABCD}) begin
                failures++;
                $display("FAIL clip_write[%0d] got wen=%b p=%0d i=%0d v=%h", i, wen, w_param, w_index, w_val);
            end
        end
        tick();
        checks++;
        if ({wen, fill_done} !== 2'b01) begin
            failures++;
            $display("FAIL clip_done got wen=%b done=%b want 0 1", wen, fill_done);
        end
        start_fill(2'd2, 11'd10, 11'd0, 16'h5A5A);
        tick();
        fill_start = 1'b0;
        checks++;
        if ({wen, fill_busy, fill_done} !== 3'b010) begin
            failures++;
            $display("FAIL zero_c1 got wen=%b busy=%b done=%b want 0 1 0", wen, fill_busy, fill_done);
        end
        tick();
        checks++;
        if ({wen, fill_busy, fill_done} !== 3'b001) begin
            failures++;
            $display("FAIL zero_c2 got wen=%b busy=%b done=%b want 0 0 1", wen, fill_busy, fill_done);
        end
        start_fill(2'd0, 11'd20, 11'd5, 16'h1111);
        tick();
        fill_start = 1'b0;
        tick();
        checks++;
        if ({wen, fill_done} !== 2'b01) begin
            failures++;
            $display("FAIL base_oor got wen=%b done=%b want 0 1", wen, fill_done);
        end
        tick();
    endtask

    task automatic test_contention();
        logic [10:0] got_i[$];
        logic [15:0] got_v[$];
        int done_t = 0;
        start_fill(2'd2, 11'd100, 11'd10, 16'h1111);
        tick();
        fill_start = 1'b0;
        for (int t = 1; t <= 14; t++) begin
            if (t == 4) begin
                cpu_req = 1'b1; cpu_param = 2'd2; cpu_index = 11'd500; cpu_val = 16'h2222;
            end
            tick();
            cpu_req = 1'b0;
            if (wen) begin
                got_i.push_back(w_index);
                got_v.push_back(w_val);
            end
            if (fill_done) done_t = t;
        end
        checks++;
        if (got_i.size() !== 11) begin
            failures++;
            $display("FAIL contend_count got=%0d want=11", got_i.size());
        end else begin
            for (int k = 0; k < 11; k++) begin
                checks++;
                if ({got_i[k], got_v[k]} !== (k == 3 ? {11'd500, 16'h2222} : {11'(k < 3 ? 100 + k : 99 + k), 16'h1111})) begin
                    failures++;
                    $display("FAIL contend_seq[%0d] got i=%0d v=%h", k, got_i[k], got_v[k]);
                end
            end
        end
        checks++;
        if (done_t !== 12) begin
            failures++;
            $display("FAIL contend_done got cycle=%0d want=12", done_t);
        end
    endtask

    task automatic test_simultaneous();
        cpu_req = 1'b1; cpu_param = 2'd1; cpu_index = 11'd7; cpu_val = 16'h0007;
        start_fill(2'd0, 11'd3, 11'd2, 16'h00F0);
        tick();
        cpu_req = 1'b0; fill_start = 1'b0;
        checks++;
        if ({wen, w_param, w_index, w_val, cpu_ack, fill_busy} !== {1'b1, 2'd1, 11'd7, 16'h0007, 2'b11}) begin
            failures++;
            $display("FAIL simul_cpu got wen=%b p=%0d i=%0d v=%h ack=%b busy=%b", wen, w_param, w_index, w_val, cpu_ack, fill_busy);
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if ({wen, w_param, w_index, w_val} !== {1'b1, 2'd0, 11'(3 + i), 16'h00F0}) begin
                failures++;
                $display("FAIL simul_fill[%0d] got wen=%b p=%0d i=%0d v=%h", i, wen, w_param, w_index, w_val);
            end
        end
        tick();
        checks++;
        if (fill_done !== 1'b1) begin
            failures++;
            $display("FAIL simul_done got %b want 1", fill_done);
        end
    endtask

    task automatic test_reset_mid_fill();
        int bad = 0;
        start_fill(2'd3, 11'd0, 11'd50, 16'h7777);
        tick();
        fill_start = 1'b0;
        repeat (5) tick();
        resetn = 1'b0;
        tick();
        checks++;
        if ({wen, cpu_ack, cpu_err, fill_busy, fill_done, w_param, w_index, w_val} !== 34'd0) begin
            failures++;
            $display("FAIL midreset_outs got=%h want=0", {wen, cpu_ack, cpu_err, fill_busy, fill_done, w_param, w_index, w_val});
        end
        resetn = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (wen || fill_done || fill_busy) bad++;
        end
        checks++;
        if (bad !== 0) begin
            failures++;
            $display("FAIL midreset_quiet got active_cycles=%0d want=0", bad);
        end
        start_fill(2'd0, 11'd14, 11'd5, 16'h0C0C);
        tick();
        fill_start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if ({wen, w_index, w_val} !== {1'b1, 11'(14 + i), 16'h0C0C}) begin
                failures++;
                $display("FAIL refill[%0d] got wen=%b i=%0d v=%h", i, wen, w_index, w_val);
            end
        end
        tick();
        checks++;
        if ({wen, fill_done} !== 2'b01) begin
            failures++;
            $display("FAIL refill_done got wen=%b done=%b want 0 1", wen, fill_done);
        end
    endtask

    task automatic test_fill_value();
`ifdef VIDEO_FILL_INC_EN
        fill_step = 16'd1;
        start_fill(2'd2, 11'd8, 11'd4, 16'h0000);
`else
        start_fill(2'd2, 11'd8, 11'd4, 16'h5555);
`endif
        tick();
        fill_start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
`ifdef VIDEO_FILL_INC_EN
            if ({wen, w_index, w_val} !== {1'b1, 11'(8 + i), 16'(i)}) begin
`else
            if ({wen, w_index, w_val} !== {1'b1, 11'(8 + i), 16'h5555}) begin
`endif
                failures++;
                $display("FAIL fill_val[%0d] got wen=%b i=%0d v=%h", i, wen, w_index, w_val);
            end
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_cpu_in_range();
        test_cpu_out_of_range();
        test_full_clear();
        test_clip_and_zero();
        test_contention();
        test_simultaneous();
        test_reset_mid_fill();
        test_fill_value();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
